// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and state encoding for the sample sequencer.
//   SEQ_W   width of the sequencer state / state_dbg LED field
//   DATA_W  default sample width (signed Q2.6 when 8 bits)
//   Q_FRAC  fractional bits of the Q-format samples
package seq_pkg;

    localparam int unsigned SEQ_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned Q_FRAC = 6;

    typedef enum logic [SEQ_W-1:0] {
        S_IDLE  = 3'd0,
        S_ADV   = 3'd1,
        S_LATCH = 3'd2,
        S_DIV   = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/step_edge_det.sv
// step_edge_det: one-register rising-edge detector for key/step levels.
//   clk     in   system clock
//   rst     in   synchronous reset, active-high; preloads the current level
//   din     in   level input
//   rise_c  out  combinational pulse, high while din=1 and last sample was 0
module step_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);

    logic prev;

    // Loading din during reset stops a level held through reset from firing.
    always_ff @(posedge clk) begin
        prev <= din;
    end

    assign rise_c = din & ~prev & ~rst;

endmodule

// File: rtl/sample_seq_ctrl.sv
// sample_seq_ctrl: sequencer for the random -> divide-by-3 -> 3-sample-sum path.
// Each step advances the LFSR, hands the new sample to the divider, shifts the
// quotient into an x/y/z window and publishes the sign-extended 3-sample sum.
// Optional macro SEQ_AUTO_RUN_EN adds the auto_run port and a periodic step.
// Ports:
//   CLOCK_50     in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   step_req     in   step level, rising edge starts a sequence
//   rand_in      in   W  current LFSR sample (signed)
//   lfsr_adv     out  one-cycle LFSR advance pulse
//   div_start    out  one-cycle divider start pulse
//   div_operand  out  W  dividend, stable while the divide runs
//   div_done     in   divider result strobe
//   div_quot     in   W  quotient, valid with div_done
//   x_out/y_out/z_out out W  newest / previous / oldest quotient
//   sum_out      out  W+2 signed x+y+z
//   sum_valid    out  one-cycle pulse when sum_out updates
//   busy         out  high outside IDLE
//   err_timeout  out  sticky divider timeout flag
//   state_dbg    out  SEQ_W state encoding
//   auto_run     in   free-run enable (SEQ_AUTO_RUN_EN only)
module sample_seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned W           = DATA_W,
    parameter int unsigned DIV_TIMEOUT = 16
`ifdef SEQ_AUTO_RUN_EN
    ,
    parameter int unsigned AUTO_PERIOD = 50000000
`endif
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             step_req,
    input  logic [W-1:0]     rand_in,
    output logic             lfsr_adv,
    output logic             div_start,
    output logic [W-1:0]     div_operand,
    input  logic             div_done,
    input  logic [W-1:0]     div_quot,
    output logic [W-1:0]     x_out,
    output logic [W-1:0]     y_out,
    output logic [W-1:0]     z_out,
    output logic [W+1:0]     sum_out,
    output logic             sum_valid,
    output logic             busy,
    output logic             err_timeout,
    output logic [SEQ_W-1:0] state_dbg
`ifdef SEQ_AUTO_RUN_EN
    ,
    input  logic             auto_run
`endif
);

    localparam int unsigned CW = $clog2(DIV_TIMEOUT) + 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [W-1:0]  quot;
    logic          step_rise_c;
    logic          step_c;

    step_edge_det u_step_edge (
        .clk    (CLOCK_50),
        .rst    (rst),
        .din    (step_req),
        .rise_c (step_rise_c)
    );

`ifdef SEQ_AUTO_RUN_EN
    localparam int unsigned AW = $clog2(AUTO_PERIOD) + 1;

    logic [AW-1:0] auto_cnt;
    logic          auto_step_c;

    assign auto_step_c = auto_run && (auto_cnt == AW'(AUTO_PERIOD - 1));

    // Free-running period counter; held at zero while auto_run is low.
    always_ff @(posedge CLOCK_50) begin
        if (rst || !auto_run) begin
            auto_cnt <= '0;
        end else if (auto_step_c) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AW'(1);
        end
    end

    assign step_c = step_rise_c | auto_step_c;
`else
    assign step_c = step_rise_c;
`endif

    assign state_dbg = state;

    // Sequencer FSM with registered strobes; triggers outside IDLE are dropped.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            quot        <= '0;
            lfsr_adv    <= 1'b0;
            div_start   <= 1'b0;
            div_operand <= '0;
            x_out       <= '0;
            y_out       <= '0;
            z_out       <= '0;
            sum_out     <= '0;
            sum_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            lfsr_adv  <= 1'b0;
            div_start <= 1'b0;
            sum_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step_c) begin
                        state    <= S_ADV;
                        lfsr_adv <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_ADV: begin
                    state <= S_LATCH;
                end
                // rand_in already reflects the advance issued in ADV.
                S_LATCH: begin
                    div_operand <= rand_in;
                    div_start   <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= S_DIV;
                end
                S_DIV: begin
                    if (div_done) begin
                        quot  <= div_quot;
                        state <= S_ACC;
                    end else if (wait_cnt == CW'(DIV_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_ACC: begin
                    z_out <= y_out;
                    y_out <= x_out;
                    x_out <= quot;
                    state <= S_DONE;
                end
                // Two guard bits keep the 3-term signed sum from wrapping.
                S_DONE: begin
                    sum_out   <= {{2{x_out[W-1]}}, x_out}
                               + {{2{y_out[W-1]}}, y_out}
                               + {{2{z_out[W-1]}}, z_out};
                    sum_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// tb_sample_seq_ctrl: randomized self-checking bench for sample_seq_ctrl.
// A behavioural divider/LFSR responder drives div_done, div_quot and rand_in;
// the x/y/z window and sum are modelled as plain integers.
// Define SEQ_AUTO_RUN_EN to also exercise the auto-run feature.
module tb_sample_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_req;
    logic [7:0] rand_in;
    logic       lfsr_adv;
    logic       div_start;
    logic [7:0] div_operand;
    logic       div_done;
    logic [7:0] div_quot;
    logic [7:0] x_out, y_out, z_out;
    logic [9:0] sum_out;
    logic       sum_valid;
    logic       busy;
    logic       err_timeout;
    logic [2:0] state_dbg;
`ifdef SEQ_AUTO_RUN_EN
    logic       auto_run;
`endif

    // responder controls
    logic [7:0] next_rand = 8'h00;
    logic [7:0] resp_quot = 8'h00;
    int         resp_lat  = 3;
    logic       resp_en   = 1'b0;
    logic       late_pulse = 1'b0;
    logic [7:0] late_quot = 8'h00;

    // reference model of the history window
    int mx, my, mz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sample_seq_ctrl #(
        .W           (8),
        .DIV_TIMEOUT (16)
`ifdef SEQ_AUTO_RUN_EN
        ,
        .AUTO_PERIOD (20)
`endif
    ) dut (
        .CLOCK_50    (clk),
        .rst         (rst),
        .step_req    (step_req),
        .rand_in     (rand_in),
        .lfsr_adv    (lfsr_adv),
        .div_start   (div_start),
        .div_operand (div_operand),
        .div_done    (div_done),
        .div_quot    (div_quot),
        .x_out       (x_out),
        .y_out       (y_out),
        .z_out       (z_out),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .busy        (busy),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
`ifdef SEQ_AUTO_RUN_EN
        ,
        .auto_run    (auto_run)
`endif
    );

    // LFSR + divider stand-in: rand_in moves one cycle after lfsr_adv,
    // div_done arrives resp_lat cycles after div_start is seen.
    initial begin
        int   pend;
        logic adv_d;
        pend     = -1;
        adv_d    = 1'b0;
        div_done = 1'b0;
        div_quot = 8'h00;
        rand_in  = 8'h00;
        forever begin
            @(posedge clk); #2;
            div_done = 1'b0;
            if (adv_d) rand_in = next_rand;
            adv_d = lfsr_adv;
            if (late_pulse) begin
                div_done = 1'b1;
                div_quot = late_quot;
            end else if (pend == 0) begin
                div_done = 1'b1;
                div_quot = resp_quot;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (div_start && resp_en) pend = resp_lat - 1;
        end
    end

    function automatic int sv8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_shift(input logic [7:0] q);
        mz = my;
        my = mx;
        mx = sv8(q);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mx = 0; my = 0; mz = 0;
    endtask

    task automatic check_window(input string tag);
        int s;
        s = int'($signed(sum_out));
        checks++;
        if (sv8(x_out) !== mx || sv8(y_out) !== my || sv8(z_out) !== mz) begin
            errors++;
            $display("FAIL %s window: xyz=%0d/%0d/%0d expected %0d/%0d/%0d",
                     tag, sv8(x_out), sv8(y_out), sv8(z_out), mx, my, mz);
        end
        checks++;
        if (s !== mx + my + mz) begin
            errors++;
            $display("FAIL %s sum: got %0d expected %0d", tag, s, mx + my + mz);
        end
    endtask

    // One full step with step_req held high throughout the sequence.
    task automatic do_step(input logic [7:0] rnew, input logic [7:0] q,
                           input int lat, input string tag);
        int adv_n = 0, adv_k = -1, ds_n = 0, ds_k = -1, sv_n = 0, sv_k = -1;
        logic [7:0] op = 8'h00;
        next_rand = rnew;
        resp_quot = q;
        resp_lat  = lat;
        resp_en   = 1'b1;
        step_req  = 1'b1;
        for (int k = 0; k < lat + 10; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv)  begin adv_n++; if (adv_k < 0) adv_k = k; end
            if (div_start) begin ds_n++;  if (ds_k < 0) begin ds_k = k; op = div_operand; end end
            if (sum_valid) begin sv_n++;  if (sv_k < 0) sv_k = k; end
            if (k == lat + 3) step_req = 1'b0;
        end
        model_shift(q);
        checks++;
        if (adv_n !== 1 || adv_k !== 0) begin
            errors++;
            $display("FAIL %s lfsr_adv: count=%0d at=%0d expected 1 at 0", tag, adv_n, adv_k);
        end
        checks++;
        if (ds_n !== 1 || ds_k !== 2) begin
            errors++;
            $display("FAIL %s div_start: count=%0d at=%0d expected 1 at 2", tag, ds_n, ds_k);
        end
        checks++;
        if (op !== rnew) begin
            errors++;
            $display("FAIL %s div_operand: got %h expected %h", tag, op, rnew);
        end
        checks++;
        if (sv_n !== 1 || sv_k !== lat + 5) begin
            errors++;
            $display("FAIL %s sum_valid: count=%0d at=%0d expected 1 at %0d", tag, sv_n, sv_k, lat + 5);
        end
        checks++;
        if (busy !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL %s idle after: busy=%b state=%0d expected 0/0", tag, busy, state_dbg);
        end
        check_window(tag);
    endtask

    task automatic test_reset();
        int adv_n = 0;
        rst = 1'b1;
        step_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mx = 0; my = 0; mz = 0;
        checks++;
        if ({lfsr_adv, div_start, div_operand, x_out, y_out, z_out, sum_out,
             sum_valid, busy, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: adv=%b ds=%b op=%h x=%h y=%h z=%h sum=%h sv=%b busy=%b err=%b expected all 0",
                     lfsr_adv, div_start, div_operand, x_out, y_out, z_out, sum_out, sum_valid, busy, err_timeout);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv) adv_n++;
        end
        checks++;
        if (adv_n !== 0) begin
            errors++;
            $display("FAIL reset_held_step: lfsr_adv count=%0d expected 0", adv_n);
        end
        step_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_step(8'h60, 8'h20, 3, "single");
    endtask

    task automatic test_history();
        do_rst();
        do_step(8'h11, 8'h20, 3, "hist1");
        do_step(8'h22, 8'h10, 2, "hist2");
        do_step(8'h33, 8'hF0, 4, "hist3");
        do_step(8'h44, 8'h80, 1, "hist4");
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            do_step(r, 8'(sv8(r) / 3), int'($urandom_range(1, 6)), "random");
        end
    endtask

    // Second step edge lands on the first cycle the FSM is back in IDLE.
    task automatic test_back_to_back();
        int lat = 3;
        int adv_n = 0, adv_k2 = -1, sv_n = 0;
        next_rand = 8'h5A;
        resp_quot = 8'h1E;
        resp_lat  = lat;
        resp_en   = 1'b1;
        step_req  = 1'b1;
        for (int k = 0; k < 2 * lat + 16; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv) begin adv_n++; if (k > 0) adv_k2 = k; end
            if (sum_valid) sv_n++;
            if (k == 2) step_req = 1'b0;
            if (k == lat + 5) step_req = 1'b1;
        end
        step_req = 1'b0;
        model_shift(8'h1E);
        model_shift(8'h1E);
        checks++;
        if (adv_n !== 2 || adv_k2 !== lat + 6) begin
            errors++;
            $display("FAIL back_to_back: adv count=%0d second at=%0d expected 2 at %0d", adv_n, adv_k2, lat + 6);
        end
        checks++;
        if (sv_n !== 2) begin
            errors++;
            $display("FAIL back_to_back sum_valid: count=%0d expected 2", sv_n);
        end
        check_window("back_to_back");
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int ds_k = -1, sv_n = 0;
        logic [2:0] st17 = 3'd7, st18 = 3'd7;
        logic err17 = 1'b1, err18 = 1'b0;
        resp_en  = 1'b0;
        next_rand = 8'h7F;
        step_req = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (div_start && ds_k < 0) ds_k = k;
            if (sum_valid) sv_n++;
            if (k == 17) begin st17 = state_dbg; err17 = err_timeout; end
            if (k == 18) begin st18 = state_dbg; err18 = err_timeout; end
            if (k == 3) step_req = 1'b0;
        end
        checks++;
        if (ds_k !== 2) begin
            errors++;
            $display("FAIL timeout div_start: at=%0d expected 2", ds_k);
        end
        checks++;
        if (st17 !== 3'd3 || st18 !== 3'd0) begin
            errors++;
            $display("FAIL timeout state: k17=%0d k18=%0d expected 3/0", st17, st18);
        end
        checks++;
        if (err17 !== 1'b0 || err18 !== 1'b1) begin
            errors++;
            $display("FAIL timeout err: k17=%b k18=%b expected 0/1", err17, err18);
        end
        checks++;
        if (sv_n !== 0) begin
            errors++;
            $display("FAIL timeout sum_valid: count=%0d expected 0", sv_n);
        end
        check_window("timeout_hold");
        do_step(8'h30, 8'h10, 2, "after_timeout");
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout sticky: err=%b expected 1", err_timeout);
        end
    endtask

    task automatic test_busy_drop();
        int adv_n = 0, sv_n = 0;
        next_rand = 8'hC3;
        resp_quot = 8'hEC;
        resp_lat  = 5;
        resp_en   = 1'b1;
        step_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv) adv_n++;
            if (sum_valid) sv_n++;
            if (k == 4) step_req = 1'b0;
            if (k == 5) step_req = 1'b1;
        end
        step_req = 1'b0;
        model_shift(8'hEC);
        checks++;
        if (adv_n !== 1 || sv_n !== 1) begin
            errors++;
            $display("FAIL busy_drop: adv=%0d sum_valid=%0d expected 1/1", adv_n, sv_n);
        end
        check_window("busy_drop");
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        int pulses = 0, busy_n = 0;
        logic [2:0] st_div = 3'd7;
        resp_en   = 1'b0;
        next_rand = 8'h44;
        step_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) st_div = state_dbg;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mx = 0; my = 0; mz = 0;
        checks++;
        if (st_div !== 3'd3) begin
            errors++;
            $display("FAIL rst_mid pre: state=%0d expected 3", st_div);
        end
        checks++;
        if (state_dbg !== 3'd0 || busy !== 1'b0 || err_timeout !== 1'b0 || div_operand !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid post: state=%0d busy=%b err=%b op=%h expected 0/0/0/00",
                     state_dbg, busy, err_timeout, div_operand);
        end
        late_pulse = 1'b1;
        late_quot  = 8'h55;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            late_pulse = 1'b0;
            if (lfsr_adv || div_start || sum_valid) pulses++;
            if (busy || state_dbg !== 3'd0) busy_n++;
        end
        step_req = 1'b0;
        checks++;
        if (pulses !== 0 || busy_n !== 0) begin
            errors++;
            $display("FAIL rst_mid late_done: pulses=%0d busy_cycles=%0d expected 0/0", pulses, busy_n);
        end
        check_window("rst_mid");
        @(posedge clk); #1;
    endtask

`ifdef SEQ_AUTO_RUN_EN
    task automatic test_auto_run();
        int adv_n = 0, sv_n = 0, last_k = -1, bad_gap = 0, first_k = -1;
        resp_quot = 8'h08;
        resp_lat  = 3;
        resp_en   = 1'b1;
        next_rand = 8'h18;
        auto_run  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv) begin
                adv_n++;
                if (first_k < 0) first_k = k;
                if (last_k >= 0 && k - last_k !== 20) bad_gap++;
                last_k = k;
            end
            if (sum_valid) sv_n++;
        end
        auto_run = 1'b0;
        checks++;
        if (adv_n !== 5 || first_k !== 19 || bad_gap !== 0) begin
            errors++;
            $display("FAIL auto_run: seqs=%0d first=%0d bad_gaps=%0d expected 5/19/0", adv_n, first_k, bad_gap);
        end
        adv_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (lfsr_adv) adv_n++;
        end
        checks++;
        if (adv_n !== 0) begin
            errors++;
            $display("FAIL auto_run off: seqs=%0d expected 0", adv_n);
        end
        do_rst();
    endtask
`endif

    initial begin
        rst      = 1'b1;
        step_req = 1'b0;
        mx = 0; my = 0; mz = 0;
`ifdef SEQ_AUTO_RUN_EN
        auto_run = 1'b0;
`endif
        test_reset();
        test_single();
        test_history();
        test_random();
        test_back_to_back();
        test_timeout();
        test_busy_drop();
        test_rst_mid();
`ifdef SEQ_AUTO_RUN_EN
        test_auto_run();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
